conv_decoder: RTL and testbench
===============================

CONV_DECODER -- requirements
Module: conv_decoder

Interface
REQ-001 SHALL expose: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL expose instruction inputs: stride_feature_baseaddr in FRAM_ADDR_WIDTH; stride_kernel_baseaddr in KRAM_ADDR_WIDTH; stride_feature_chin/chout/width/height, stride_kernel_sizeh/sizew in 32; stride_has_bias, stride_has_relu in 1; stride_wb_baseaddr in FRAM_ADDR_WIDTH.
REQ-004 SHALL expose: inst_valid in 1 instruction offered; decoder_ready out 1 instruction accepted when both high.
REQ-005 SHALL expose: fram_rd_en out 1; fram_rd_addr out FRAM_ADDR_WIDTH; kram_rd_en out 1; kram_rd_addr out KRAM_ADDR_WIDTH.
REQ-006 SHALL expose: mac_valid out 1 (RAM data valid this cycle); mac_first out 1 (first tap of an output channel); mac_last out 1 (last tap); bias_valid out 1 (kernel data is bias word).
REQ-007 SHALL expose: wb_valid out 1; wb_ready in 1; wb_addr out FRAM_ADDR_WIDTH; wb_chout out 32 (output channel index); wb_relu out 1.

Function
REQ-008 States SHALL be IDLE, LOAD, ISSUE, BIAS, WB; decoder_ready = (state==IDLE).
REQ-009 Handshake in IDLE SHALL register all instruction fields and go to LOAD; fields SHALL remain stable until return to IDLE.
REQ-010 LOAD (1 cycle) SHALL compute plane = width*height (32-bit, truncated), clear counters co, ci, kh, kw, set kernel pointer kp = kernel base; then go to ISSUE, or to IDLE directly if chin, chout, sizeh or sizew is zero (no reads, no wb).
REQ-011 ISSUE SHALL assert fram_rd_en and kram_rd_en every cycle with fram_rd_addr = fbase + ci*plane + kh*width + kw and kram_rd_addr = kp, computed by incremental row/channel base registers (no per-cycle multiply).
REQ-012 Counter nesting per cycle SHALL be kw innermost, then kh, then ci; kp SHALL increment by 1 per issued read; all address sums wrap modulo their port width.
REQ-013 After the tap ci=chin-1, kh=sizeh-1, kw=sizew-1, next state SHALL be BIAS if has_bias else WB.
REQ-014 BIAS (1 cycle) SHALL assert kram_rd_en only, address kp, then kp+=1 and go to WB.
REQ-015 Read latency is 1 cycle: mac_valid, mac_first, mac_last, bias_valid SHALL be the 1-cycle-delayed image of the issuing cycle's rd_en/first-tap/last-tap/bias flags.
REQ-016 WB SHALL hold wb_valid=1, wb_addr=stride_wb_baseaddr, wb_chout=co, wb_relu=has_relu until wb_ready; on handshake co+=1; if co==chout-1 go IDLE else clear ci/kh/kw and return to ISSUE.
REQ-017 wb_valid SHALL not assert before the last mac_valid/bias_valid of that channel has been emitted (guaranteed by WB entry one cycle after final issue).
REQ-018 Single-tap case (chin=sizeh=sizew=1) SHALL assert mac_first and mac_last in the same cycle.
REQ-019 inst_valid outside IDLE SHALL be ignored.

Reset
REQ-020 With rst high at a clock edge: state=IDLE, all counters and pipeline flags zero, all rd_en/mac_*/bias_valid/wb_valid = 0, address outputs 0; an operation in progress SHALL be abandoned without further outputs.

Structure
REQ-021 State enum and flag widths SHALL live in the shared package alongside defines.sv macros (FRAM_ADDR_WIDTH, KRAM_ADDR_WIDTH, DATA_RANGE).
REQ-022 The tap-address walker (ci/kh/kw counters plus incremental base registers) SHALL be one sub-module, conv_tap_walker; the FSM and 1-cycle output pipeline stay in conv_decoder.

Verification
REQ-023 chin=1, chout=1, 3x3 kernel, width=5, fbase=10, kbase=0, no bias -> 9 reads, fram addrs 10,11,12,15,16,17,20,21,22; kram 0..8; mac_first with addr 10 data, mac_last with 22; one wb.
REQ-024 chin=2, chout=2, 1x1, width=4, height=4, bias=1 -> per channel fram 0,16; kram 0,1,bias 2 then 3,4,bias 5; two wb with wb_chout 0,1.
REQ-025 wb_ready low 5 cycles in WB -> wb_valid held, no reads issued, outputs stable; resumes next cycle after handshake.
REQ-026 chout=0 -> accepted, back to IDLE after LOAD, no rd_en, no wb_valid.
REQ-027 rst asserted mid-ISSUE -> next cycle all outputs 0, decoder_ready=1; subsequent instruction runs correctly from start.
REQ-028 fbase=FRAM max-2, 1x3 kernel -> addresses wrap to max-2, max-1, 0.

Source files
------------

// File: rtl/conv_decoder_pkg.sv
// conv_decoder_pkg: shared widths, FSM state encoding and the latched instruction record.
package conv_decoder_pkg;
    localparam int FRAM_ADDR_WIDTH = 16;
    localparam int KRAM_ADDR_WIDTH = 12;
    localparam int DATA_RANGE      = 16;

    typedef logic [FRAM_ADDR_WIDTH-1:0] faddr_t;
    typedef logic [KRAM_ADDR_WIDTH-1:0] kaddr_t;
    typedef logic [DATA_RANGE-1:0]      data_t;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, BIAS, WB} state_e;

    typedef struct packed {
        faddr_t      fbase;
        kaddr_t      kbase;
        logic [31:0] chin;
        logic [31:0] chout;
        logic [31:0] width;
        logic [31:0] height;
        logic [31:0] sizeh;
        logic [31:0] sizew;
        logic        has_bias;
        logic        has_relu;
        faddr_t      wbase;
    } inst_t;
endpackage

// File: rtl/conv_decoder_if.sv
// conv_decoder_if: instruction, RAM-read, MAC-flag and write-back signals of the decoder.
interface conv_decoder_if;
    import conv_decoder_pkg::*;
    faddr_t      stride_feature_baseaddr;
    kaddr_t      stride_kernel_baseaddr;
    logic [31:0] stride_feature_chin;
    logic [31:0] stride_feature_chout;
    logic [31:0] stride_feature_width;
    logic [31:0] stride_feature_height;
    logic [31:0] stride_kernel_sizeh;
    logic [31:0] stride_kernel_sizew;
    logic        stride_has_bias;
    logic        stride_has_relu;
    faddr_t      stride_wb_baseaddr;
    logic        inst_valid;
    logic        decoder_ready;
    logic        fram_rd_en;
    faddr_t      fram_rd_addr;
    logic        kram_rd_en;
    kaddr_t      kram_rd_addr;
    logic        mac_valid;
    logic        mac_first;
    logic        mac_last;
    logic        bias_valid;
    logic        wb_valid;
    logic        wb_ready;
    faddr_t      wb_addr;
    logic [31:0] wb_chout;
    logic        wb_relu;

    modport master (
        output stride_feature_baseaddr, stride_kernel_baseaddr, stride_feature_chin,
               stride_feature_chout, stride_feature_width, stride_feature_height,
               stride_kernel_sizeh, stride_kernel_sizew, stride_has_bias, stride_has_relu,
               stride_wb_baseaddr, inst_valid, wb_ready,
        input  decoder_ready, fram_rd_en, fram_rd_addr, kram_rd_en, kram_rd_addr,
               mac_valid, mac_first, mac_last, bias_valid, wb_valid, wb_addr, wb_chout, wb_relu
    );
    modport slave (
        input  stride_feature_baseaddr, stride_kernel_baseaddr, stride_feature_chin,
               stride_feature_chout, stride_feature_width, stride_feature_height,
               stride_kernel_sizeh, stride_kernel_sizew, stride_has_bias, stride_has_relu,
               stride_wb_baseaddr, inst_valid, wb_ready,
        output decoder_ready, fram_rd_en, fram_rd_addr, kram_rd_en, kram_rd_addr,
               mac_valid, mac_first, mac_last, bias_valid, wb_valid, wb_addr, wb_chout, wb_relu
    );
endinterface

// File: rtl/conv_tap_walker.sv
// conv_tap_walker: walks kw/kh/ci taps, keeping channel and row base addresses
// incrementally so the feature address needs only one add per cycle.
module conv_tap_walker
    import conv_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        step_i,
    input  faddr_t      fbase_i,
    input  faddr_t      plane_i,
    input  faddr_t      width_i,
    input  logic [31:0] chin_i,
    input  logic [31:0] sizeh_i,
    input  logic [31:0] sizew_i,
    output faddr_t      addr_o,
    output logic        first_o,
    output logic        last_o
);
    logic [31:0] ci_q, kh_q, kw_q;
    faddr_t      ch_q, row_q;
    logic        kw_end, kh_end, ci_end;

    assign kw_end  = kw_q == sizew_i - 32'd1;
    assign kh_end  = kh_q == sizeh_i - 32'd1;
    assign ci_end  = ci_q == chin_i - 32'd1;
    assign addr_o  = row_q + faddr_t'(kw_q);
    assign first_o = ci_q == '0 && kh_q == '0 && kw_q == '0;
    assign last_o  = ci_end && kh_end && kw_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            ci_q  <= '0;
            kh_q  <= '0;
            kw_q  <= '0;
            ch_q  <= '0;
            row_q <= '0;
        end else if (clear_i) begin
            ci_q  <= '0;
            kh_q  <= '0;
            kw_q  <= '0;
            ch_q  <= fbase_i;
            row_q <= fbase_i;
        end else if (step_i) begin
            kw_q <= kw_end ? '0 : kw_q + 32'd1;
            if (kw_end) begin
                kh_q <= kh_end ? '0 : kh_q + 32'd1;
                if (!kh_end) begin
                    row_q <= row_q + width_i;
                end else begin
                    // Channel wrap returns both bases to the feature origin for the next output channel.
                    ci_q  <= ci_end ? '0 : ci_q + 32'd1;
                    ch_q  <= ci_end ? fbase_i : ch_q + plane_i;
                    row_q <= ci_end ? fbase_i : ch_q + plane_i;
                end
            end
        end
    end
endmodule

// File: rtl/conv_decoder.sv
// conv_decoder: sequences one convolution instruction into feature/kernel RAM reads,
// delayed MAC tap flags and one write-back handshake per output channel.
module conv_decoder
    import conv_decoder_pkg::*;
(
    input logic           clk,
    input logic           rst,
    conv_decoder_if.slave bus
);
    state_e      state_q;
    inst_t       inst_q;
    faddr_t      plane_q;
    kaddr_t      kp_q;
    logic [31:0] co_q;
    logic        mac_valid_q, mac_first_q, mac_last_q, bias_valid_q;
    faddr_t      tap_addr;
    logic        tap_first, tap_last;
    logic        issue, bias, wb, wb_hs, kr_en, empty;

    assign issue = state_q == ISSUE;
    assign bias  = state_q == BIAS;
    assign wb    = state_q == WB;
    assign wb_hs = wb && bus.wb_ready;
    assign kr_en = issue || bias;
    assign empty = inst_q.chin == '0 || inst_q.chout == '0 || inst_q.sizeh == '0 || inst_q.sizew == '0;

    conv_tap_walker u_walker (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == LOAD || wb_hs),
        .step_i  (issue),
        .fbase_i (inst_q.fbase),
        .plane_i (plane_q),
        .width_i (faddr_t'(inst_q.width)),
        .chin_i  (inst_q.chin),
        .sizeh_i (inst_q.sizeh),
        .sizew_i (inst_q.sizew),
        .addr_o  (tap_addr),
        .first_o (tap_first),
        .last_o  (tap_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_q       <= '0;
            plane_q      <= '0;
            kp_q         <= '0;
            co_q         <= '0;
            mac_valid_q  <= 1'b0;
            mac_first_q  <= 1'b0;
            mac_last_q   <= 1'b0;
            bias_valid_q <= 1'b0;
        end else begin
            mac_valid_q  <= issue;
            mac_first_q  <= issue && tap_first;
            mac_last_q   <= issue && tap_last;
            bias_valid_q <= bias;
            case (state_q)
                IDLE: if (bus.inst_valid) begin
                    inst_q <= '{fbase: bus.stride_feature_baseaddr, kbase: bus.stride_kernel_baseaddr,
                               chin: bus.stride_feature_chin, chout: bus.stride_feature_chout,
                               width: bus.stride_feature_width, height: bus.stride_feature_height,
                               sizeh: bus.stride_kernel_sizeh, sizew: bus.stride_kernel_sizew,
                               has_bias: bus.stride_has_bias, has_relu: bus.stride_has_relu,
                               wbase: bus.stride_wb_baseaddr};
                    state_q <= LOAD;
                end
                LOAD: begin
                    plane_q <= faddr_t'(inst_q.width * inst_q.height);
                    kp_q    <= inst_q.kbase;
                    co_q    <= '0;
                    state_q <= empty ? IDLE : ISSUE;
                end
                ISSUE: begin
                    kp_q <= kp_q + kaddr_t'(1);
                    if (tap_last) state_q <= inst_q.has_bias ? BIAS : WB;
                end
                BIAS: begin
                    kp_q    <= kp_q + kaddr_t'(1);
                    state_q <= WB;
                end
                WB: if (bus.wb_ready) begin
                    co_q    <= co_q + 32'd1;
                    state_q <= co_q == inst_q.chout - 32'd1 ? IDLE : ISSUE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.decoder_ready = state_q == IDLE;
    assign bus.fram_rd_en    = issue;
    assign bus.fram_rd_addr  = issue ? tap_addr : '0;
    assign bus.kram_rd_en    = kr_en;
    assign bus.kram_rd_addr  = kr_en ? kp_q : '0;
    assign bus.mac_valid     = mac_valid_q;
    assign bus.mac_first     = mac_first_q;
    assign bus.mac_last      = mac_last_q;
    assign bus.bias_valid    = bias_valid_q;
    assign bus.wb_valid      = wb;
    assign bus.wb_addr       = wb ? inst_q.wbase : '0;
    assign bus.wb_chout      = wb ? co_q : '0;
    assign bus.wb_relu       = wb && inst_q.has_relu;
endmodule

// File: tb/tb_conv_decoder.sv
// tb_conv_decoder: directed vector table plus stall, reset-abort and wrap sequences.
module tb_conv_decoder;
    import conv_decoder_pkg::*;

    typedef struct {
        int fb; int kb; int chin; int chout; int w; int h; int sh; int sw;
        bit bias; bit relu; int wbase; int n_rd; int fa; int la;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t v[7];

    conv_decoder_if bus();
    conv_decoder dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int   rq[$], kq[$], fq[$], lq[$], wq[$], waq[$], wrq[$];
    int   last_rd, mv_cnt, bv_cnt, both_cnt;

    always @(negedge clk) begin
        if (bus.mac_first) fq.push_back(last_rd);
        if (bus.mac_last) lq.push_back(last_rd);
        if (bus.mac_first && bus.mac_last) both_cnt++;
        if (bus.mac_valid) mv_cnt++;
        if (bus.bias_valid) bv_cnt++;
        if (bus.fram_rd_en) begin
            rq.push_back(int'(bus.fram_rd_addr));
            last_rd = int'(bus.fram_rd_addr);
        end
        if (bus.kram_rd_en) kq.push_back(int'(bus.kram_rd_addr));
        if (bus.wb_valid && bus.wb_ready) begin
            wq.push_back(int'(bus.wb_chout));
            waq.push_back(int'(bus.wb_addr));
            wrq.push_back(int'(bus.wb_relu));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        bus.stride_feature_baseaddr = faddr_t'(t.fb);
        bus.stride_kernel_baseaddr  = kaddr_t'(t.kb);
        bus.stride_feature_chin     = t.chin;
        bus.stride_feature_chout    = t.chout;
        bus.stride_feature_width    = t.w;
        bus.stride_feature_height   = t.h;
        bus.stride_kernel_sizeh     = t.sh;
        bus.stride_kernel_sizew     = t.sw;
        bus.stride_has_bias         = t.bias;
        bus.stride_has_relu         = t.relu;
        bus.stride_wb_baseaddr      = faddr_t'(t.wbase);
        bus.inst_valid              = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t t;
        int ef[$], ek[$];
        int k, n;
        bit done;
        t = v[idx];
        rq.delete(); kq.delete(); fq.delete(); lq.delete(); wq.delete(); waq.delete(); wrq.delete();
        mv_cnt = 0; bv_cnt = 0; both_cnt = 0;
        drive(t);
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (bus.decoder_ready) done = 1'b1;
            else tick();
        end
        chk($sformatf("v%0d_done", idx), done, 1);
        k = t.kb;
        for (int co = 0; co < t.chout; co++) begin
            for (int ci = 0; ci < t.chin; ci++)
                for (int kh = 0; kh < t.sh; kh++)
                    for (int kw = 0; kw < t.sw; kw++) begin
                        ef.push_back((t.fb + ci * t.w * t.h + kh * t.w + kw) & 32'hFFFF);
                        ek.push_back(k & 32'hFFF);
                        k++;
                    end
            if (t.bias) begin
                ek.push_back(k & 32'hFFF);
                k++;
            end
        end
        chk($sformatf("v%0d_nrd", idx), rq.size(), t.n_rd);
        chk($sformatf("v%0d_model_nrd", idx), rq.size(), ef.size());
        n = rq.size() < ef.size() ? rq.size() : ef.size();
        for (int i = 0; i < n; i++) chk($sformatf("v%0d_fram[%0d]", idx, i), rq[i], ef[i]);
        chk($sformatf("v%0d_nkram", idx), kq.size(), ek.size());
        n = kq.size() < ek.size() ? kq.size() : ek.size();
        for (int i = 0; i < n; i++) chk($sformatf("v%0d_kram[%0d]", idx, i), kq[i], ek[i]);
        chk($sformatf("v%0d_mac_valid_cnt", idx), mv_cnt, t.n_rd);
        chk($sformatf("v%0d_bias_cnt", idx), bv_cnt, t.bias ? t.chout : 0);
        chk($sformatf("v%0d_nfirst", idx), fq.size(), t.n_rd > 0 ? t.chout : 0);
        chk($sformatf("v%0d_nlast", idx), lq.size(), t.n_rd > 0 ? t.chout : 0);
        chk($sformatf("v%0d_both", idx), both_cnt, (t.chin * t.sh * t.sw == 1) ? t.chout : 0);
        if (fq.size() > 0) chk($sformatf("v%0d_first_addr", idx), fq[0], t.fa);
        if (lq.size() > 0) chk($sformatf("v%0d_last_addr", idx), lq[$], t.la);
        chk($sformatf("v%0d_nwb", idx), wq.size(), t.n_rd > 0 ? t.chout : 0);
        foreach (wq[i]) begin
            chk($sformatf("v%0d_wb_chout[%0d]", idx, i), wq[i], i);
            chk($sformatf("v%0d_wb_addr[%0d]", idx, i), waq[i], t.wbase);
            chk($sformatf("v%0d_wb_relu[%0d]", idx, i), wrq[i], t.relu);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, bus.decoder_ready, 1);
        chk({tag, "_fram_en"}, bus.fram_rd_en, 0);
        chk({tag, "_kram_en"}, bus.kram_rd_en, 0);
        chk({tag, "_fram_addr"}, bus.fram_rd_addr, 0);
        chk({tag, "_kram_addr"}, bus.kram_rd_addr, 0);
        chk({tag, "_mac_valid"}, bus.mac_valid, 0);
        chk({tag, "_bias_valid"}, bus.bias_valid, 0);
        chk({tag, "_wb_valid"}, bus.wb_valid, 0);
    endtask

    initial begin
        vec_t s;
        bit seen;
        v[0] = '{10, 0, 1, 1, 5, 5, 3, 3, 1'b0, 1'b0, 200, 9, 10, 22};
        v[1] = '{0, 0, 2, 2, 4, 4, 1, 1, 1'b1, 1'b1, 300, 4, 0, 16};
        v[2] = '{5, 0, 1, 0, 4, 4, 2, 2, 1'b0, 1'b0, 0, 0, -1, -1};
        v[3] = '{65534, 0, 1, 1, 8, 1, 1, 3, 1'b0, 1'b0, 1, 3, 65534, 0};
        v[4] = '{0, 0, 1, 1, 4, 4, 0, 2, 1'b0, 1'b0, 0, 0, -1, -1};
        v[5] = '{7, 100, 1, 1, 2, 2, 1, 1, 1'b0, 1'b1, 50, 1, 7, 7};
        v[6] = '{100, 20, 2, 1, 3, 3, 2, 2, 1'b1, 1'b0, 400, 8, 100, 113};
        bus.inst_valid = 1'b0;
        bus.wb_ready   = 1'b1;
        drive(v[0]);
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        foreach (v[i]) run_vec(i);

        // Write-back stall: held output, no reads, then resume right after the handshake.
        s = '{0, 0, 1, 2, 2, 2, 1, 1, 1'b0, 1'b1, 77, 2, 0, 0};
        bus.wb_ready = 1'b0;
        drive(s);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (bus.wb_valid) seen = 1'b1;
            else tick();
        end
        chk("stall_wb_seen", seen, 1);
        for (int c = 0; c < 5; c++) begin
            chk("stall_wb_valid", bus.wb_valid, 1);
            chk("stall_fram_en", bus.fram_rd_en, 0);
            chk("stall_kram_en", bus.kram_rd_en, 0);
            chk("stall_wb_chout", bus.wb_chout, 0);
            chk("stall_wb_addr", bus.wb_addr, 77);
            chk("stall_wb_relu", bus.wb_relu, 1);
            tick();
        end
        bus.wb_ready = 1'b1;
        tick();
        chk("resume_fram_en", bus.fram_rd_en, 1);
        chk("resume_wb_valid", bus.wb_valid, 0);
        tick();
        chk("resume_wb2_valid", bus.wb_valid, 1);
        chk("resume_wb2_chout", bus.wb_chout, 1);
        tick();
        chk("resume_idle", bus.decoder_ready, 1);

        // Reset in the middle of ISSUE abandons the operation; a fresh one then runs cleanly.
        drive(v[6]);
        tick();
        tick();
        chk("mid_in_issue", bus.fram_rd_en, 1);
        bus.inst_valid = 1'b1;
        tick();
        chk("ignored_inst_busy", bus.decoder_ready, 0);
        bus.inst_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk_idle("mid_reset");
        rst = 1'b0;
        tick();
        chk_idle("post_reset");
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
